// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// presents the held instruction plus its PC+4 to IF/ID under stall/redirect control.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        branchtakken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Inst,
   output logic [31:0] PC_addr_out,
   output logic [31:0] PC,
   output logic        inst_valid
);

   typedef enum logic [1:0] {StIdle, StFetch, StHave, StDrain} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] req_addr_q;
   logic [31:0] inst_buf_q;

   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign target   = branch_target & 32'hFFFF_FFFC;
   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         inst_buf_q <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               req_addr_q <= pc_q;
               state_q    <= StFetch;
            end
            StFetch: begin
               if (branchtakken) begin
                  pc_q <= target;
                  // With ack the redirect can be issued at once; otherwise drain first.
                  if (imem_ack) begin
                     req_addr_q <= target;
                  end else begin
                     state_q <= StDrain;
                  end
               end else if (imem_ack) begin
                  inst_buf_q <= imem_rdata;
                  state_q    <= StHave;
               end
            end
            StDrain: begin
               if (branchtakken) begin
                  pc_q <= target;
               end
               if (imem_ack) begin
                  req_addr_q <= branchtakken ? target : pc_q;
                  state_q    <= StFetch;
               end
            end
            StHave: begin
               if (branchtakken) begin
                  pc_q       <= target;
                  req_addr_q <= target;
                  state_q    <= StFetch;
               end else if (!PCWrite) begin
                  pc_q       <= pc_plus4;
                  req_addr_q <= pc_plus4;
                  state_q    <= StFetch;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs depend only on registered state; no path from imem_* inputs.
   assign imem_req    = (state_q == StFetch) || (state_q == StDrain);
   assign imem_addr   = req_addr_q;
   assign inst_valid  = (state_q == StHave);
   assign Inst        = (state_q == StHave) ? inst_buf_q : 32'd0;
   assign PC_addr_out = pc_plus4;
   assign PC          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory
// returning addr ^ 0xA5A5_0000.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        PCWrite;
   logic        branchtakken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] Inst;
   logic [31:0] PC_addr_out;
   logic [31:0] PC;
   logic        inst_valid;

   int unsigned lat;
   int unsigned cnt;
   int          errors = 0;
   int          checks = 0;

   fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
      .clock        (clock),
      .reset        (reset),
      .PCWrite      (PCWrite),
      .branchtakken (branchtakken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .Inst         (Inst),
      .PC_addr_out  (PC_addr_out),
      .PC           (PC),
      .inst_valid   (inst_valid)
   );

   always #5 clock = ~clock;

   // Memory acks once the request has been high for lat+1 cycles.
   assign imem_ack   = imem_req && (cnt == lat);
   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   always @(posedge clock or posedge reset) begin
      if (reset) cnt <= 0;
      else if (!imem_req || imem_ack) cnt <= 0;
      else cnt <= cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; PCWrite = 1'b0; branchtakken = 1'b0; branch_target = 32'd0; lat = 0;
      step(); step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0040_0000);
      chk("rst_inst", Inst, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_pc", PC, 32'h0040_0000);
      chk("rst_pc4", PC_addr_out, 32'h0040_0004);
      reset = 1'b0;

      step(); // +1
      chk("f1_req", {31'd0, imem_req}, 32'd1);
      chk("f1_addr", imem_addr, 32'h0040_0000);
      step(); // +2
      chk("f2_inst", Inst, 32'hA5E5_0000);
      chk("f2_pc4", PC_addr_out, 32'h0040_0004);
      chk("f2_valid", {31'd0, inst_valid}, 32'd1);
      step(); // +3
      chk("f3_addr", imem_addr, 32'h0040_0004);
      PCWrite = 1'b1;

      step(); // +4 HAVE, stalled
      chk("st_inst0", Inst, 32'hA5E5_0004);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_inst", Inst, 32'hA5E5_0004);
         chk("st_pc4", PC_addr_out, 32'h0040_0008);
         chk("st_pc", PC, 32'h0040_0004);
         chk("st_req", {31'd0, imem_req}, 32'd0);
      end
      PCWrite = 1'b0;
      step();
      chk("st_rel_addr", imem_addr, 32'h0040_0008);
      chk("st_rel_req", {31'd0, imem_req}, 32'd1);
      step();
      chk("st_rel_inst", Inst, 32'hA5E5_0008);

      // Branch from HAVE.
      branchtakken = 1'b1; branch_target = 32'h0000_0100;
      step();
      branchtakken = 1'b0;
      chk("bh_addr", imem_addr, 32'h0000_0100);
      chk("bh_req", {31'd0, imem_req}, 32'd1);
      chk("bh_inst", Inst, 32'd0);
      chk("bh_valid", {31'd0, inst_valid}, 32'd0);
      step();
      chk("bh_inst2", Inst, 32'hA5A5_0100);
      chk("bh_pc4", PC_addr_out, 32'h0000_0104);

      // Branch during a 3-cycle-latency request.
      lat = 2; branchtakken = 1'b1; branch_target = 32'h0000_0020;
      step();
      chk("bd_addr0", imem_addr, 32'h0000_0020);
      branch_target = 32'h0000_0200;
      step();
      branchtakken = 1'b0;
      chk("bd_addr1", imem_addr, 32'h0000_0020);
      chk("bd_req1", {31'd0, imem_req}, 32'd1);
      chk("bd_pc1", PC, 32'h0000_0200);
      step();
      chk("bd_addr2", imem_addr, 32'h0000_0020);
      chk("bd_valid2", {31'd0, inst_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bd_naddr", imem_addr, 32'h0000_0200);
         chk("bd_nvalid", {31'd0, inst_valid}, 32'd0);
         chk("bd_ninst", Inst, 32'd0);
      end
      step();
      chk("bd_inst", Inst, 32'hA5A5_0200);
      chk("bd_valid", {31'd0, inst_valid}, 32'd1);

      // Wrap at the top of the address space.
      lat = 0; branchtakken = 1'b1; branch_target = 32'hFFFF_FFFC;
      step();
      branchtakken = 1'b0;
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wr_pc4a", PC_addr_out, 32'h0000_0000);
      step();
      chk("wr_inst", Inst, 32'h5A5A_FFFC);
      chk("wr_pc4b", PC_addr_out, 32'h0000_0000);
      step();
      chk("wr_next", imem_addr, 32'h0000_0000);
      chk("wr_pc", PC, 32'h0000_0000);
      step();
      chk("wr_inst2", Inst, 32'hA5A5_0000);

      // Misaligned target, then reset mid-fetch.
      lat = 2; branchtakken = 1'b1; branch_target = 32'h0000_0103;
      step();
      branchtakken = 1'b0;
      chk("ma_addr", imem_addr, 32'h0000_0100);
      chk("ma_pc", PC, 32'h0000_0100);
      chk("ma_req", {31'd0, imem_req}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rm_req", {31'd0, imem_req}, 32'd0);
      chk("rm_pc", PC, 32'h0040_0000);
      chk("rm_addr", imem_addr, 32'h0040_0000);
      step();
      reset = 1'b0; lat = 0;
      step();
      chk("rr_req", {31'd0, imem_req}, 32'd1);
      chk("rr_addr", imem_addr, 32'h0040_0000);
      step();
      chk("rr_inst", Inst, 32'hA5E5_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
